// File: rtl/tdc_tx_framer_if.sv
// Bundles the word-input handshake and the UART launch/done signals of the
// TDC byte framer; slave is the framer's view, master is the surrounding logic.
interface tdc_tx_framer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NB     = 8
);
  logic              i_Data_Valid;
  logic [DATA_W-1:0] i_Data;
  logic              o_Data_Ready;
  logic              i_Tx_Active;
  logic              i_Tx_Done;
  logic              o_Tx_DV;
  logic [NB-1:0]     o_Tx_Byte;
  logic              o_Busy;
  logic              o_Overflow;

  modport slave (
    input  i_Data_Valid,
    input  i_Data,
    input  i_Tx_Active,
    input  i_Tx_Done,
    output o_Data_Ready,
    output o_Tx_DV,
    output o_Tx_Byte,
    output o_Busy,
    output o_Overflow
  );

  modport master (
    output i_Data_Valid,
    output i_Data,
    output i_Tx_Active,
    output i_Tx_Done,
    input  o_Data_Ready,
    input  o_Tx_DV,
    input  o_Tx_Byte,
    input  o_Busy,
    input  o_Overflow
  );
endinterface

// File: rtl/tdc_tx_framer.sv
// Buffers TDC words in a small FIFO and emits each one to the UART transmitter
// as HEADER, data bytes MSB-first, then an XOR checksum of the data bytes.
module tdc_tx_framer #(
  parameter int unsigned    DATA_W     = 32,
  parameter int unsigned    NB         = 8,
  parameter int unsigned    FIFO_DEPTH = 4,
  parameter logic [NB-1:0]  HEADER     = 8'hA5
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  tdc_tx_framer_if.slave   bus_if
);

  localparam int unsigned K     = DATA_W / NB;
  localparam int unsigned IDX_W = $clog2(K + 2);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  function automatic logic [NB-1:0] csum_fold(input logic [NB-1:0] acc,
                                              input logic [NB-1:0] data_byte);
    return acc ^ data_byte;
  endfunction

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              ovf_q;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [NB-1:0]     csum_q;
  logic [DATA_W-1:0] shift_q;
  logic              tx_dv_q;
  logic [NB-1:0]     tx_byte_q;

  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic [NB-1:0]     byte_s;

  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == '0);
  assign push_s  = bus_if.i_Data_Valid && !full_s;
  // Popping only while idle and the line is free guarantees no launch into a busy transmitter.
  assign pop_s   = (state_q == ST_IDLE) && !empty_s && !bus_if.i_Tx_Active;

  // Occupancy next-state: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // FIFO storage array, written on every accepted word.
  always_ff @(posedge i_Clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus_if.i_Data;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      if (bus_if.i_Data_Valid && full_s) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Selects the frame byte for the current index.
  always_comb begin
    byte_s = HEADER;
    if (idx_q == '0) begin
      byte_s = HEADER;
    end else if (idx_q == LAST_IDX) begin
      byte_s = csum_q;
    end else begin
      byte_s = shift_q[DATA_W-1 -: NB];
    end
  end

  // Frame sequencer with registered launch pulse and byte.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      csum_q    <= '0;
      shift_q   <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      tx_dv_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            shift_q <= mem_q[rd_ptr_q];
            csum_q  <= '0;
            idx_q   <= '0;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tx_dv_q   <= 1'b1;
          tx_byte_q <= byte_s;
          if ((idx_q != '0) && (idx_q != LAST_IDX)) begin
            csum_q  <= csum_fold(csum_q, byte_s);
            shift_q <= shift_q << NB;
          end
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus_if.i_Tx_Done) begin
            if (idx_q < LAST_IDX) begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= ST_ISSUE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_if.o_Data_Ready = !full_s;
  assign bus_if.o_Tx_DV      = tx_dv_q;
  assign bus_if.o_Tx_Byte    = tx_byte_q;
  assign bus_if.o_Busy       = (state_q != ST_IDLE);
  assign bus_if.o_Overflow   = ovf_q;

endmodule

// File: tb/tb_tdc_tx_framer.sv
// Directed bench for tdc_tx_framer: a frame-level byte model plus a UART
// stand-in, with literal expectations for selected frames and timings.
module tb_tdc_tx_framer;

  localparam int DATA_W   = 32;
  localparam int NB       = 8;
  localparam int K        = DATA_W / NB;
  localparam int FL       = K + 2;
  localparam int UART_LEN = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tdc_tx_framer_if #(.DATA_W(DATA_W), .NB(NB)) bus_if ();

  tdc_tx_framer #(
    .DATA_W(DATA_W), .NB(NB), .FIFO_DEPTH(4), .HEADER(8'hA5)
  ) dut (
    .i_Clock  (clk),
    .i_Reset_n(rst_n),
    .bus_if   (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_bytes [$];
  logic [7:0] obs_log   [$];
  int   rd         = 0;
  logic exp_ovf    = 1'b0;
  logic stall      = 1'b0;
  int   inject_req = 0;
  int   inject_ack = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte i of the frame for word w, straight from the framing rules.
  function automatic logic [7:0] frame_byte(input logic [31:0] w, input int i);
    logic [7:0] x;
    x = 8'h00;
    if (i == 0) return 8'hA5;
    if (i <= K) return 8'((w >> (8 * (K - i))) & 32'hFF);
    for (int j = 0; j < K; j++) x = x ^ 8'((w >> (8 * j)) & 32'hFF);
    return x;
  endfunction

  // Negedge: check outputs, advance the byte model, then step the UART stand-in.
  initial begin
    logic dv_prev;
    int   cnt;
    dv_prev = 1'b0;
    cnt     = 0;
    bus_if.i_Tx_Active = 1'b0;
    bus_if.i_Tx_Done   = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.o_Tx_DV) begin
        check("dv_while_active", bus_if.i_Tx_Active, 1'b0);
        check("dv_width", dv_prev, 1'b0);
        check("dv_expected", (rd < exp_bytes.size()), 1'b1);
        if (rd < exp_bytes.size()) begin
          check("frame_byte", bus_if.o_Tx_Byte, exp_bytes[rd]);
          rd++;
        end
        obs_log.push_back(bus_if.o_Tx_Byte);
      end
      dv_prev = bus_if.o_Tx_DV;
      check("overflow_flag", bus_if.o_Overflow, exp_ovf);

      if (!rst_n) begin
        rd      = exp_bytes.size();
        exp_ovf = 1'b0;
      end else if (bus_if.i_Data_Valid) begin
        if (bus_if.o_Data_Ready) begin
          for (int i = 0; i < FL; i++) exp_bytes.push_back(frame_byte(bus_if.i_Data, i));
        end else begin
          exp_ovf = 1'b1;
        end
      end

      bus_if.i_Tx_Done = 1'b0;
      if (inject_req != inject_ack) begin
        inject_ack       = inject_req;
        bus_if.i_Tx_Done = 1'b1;
      end
      if (bus_if.o_Tx_DV && !bus_if.i_Tx_Active) begin
        bus_if.i_Tx_Active = 1'b1;
        cnt                = UART_LEN;
      end else if (bus_if.i_Tx_Active && !stall) begin
        cnt--;
        if (cnt == 0) begin
          bus_if.i_Tx_Active = 1'b0;
          bus_if.i_Tx_Done   = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    bus_if.i_Data_Valid = 1'b1;
    bus_if.i_Data       = w;
    tick();
    bus_if.i_Data_Valid = 1'b0;
  endtask

  task automatic wait_log(input int target, input int budget, input string name);
    int n;
    n = 0;
    while ((obs_log.size() < target) && (n < budget)) begin
      tick();
      n++;
    end
    check(name, (obs_log.size() >= target), 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (bus_if.o_Busy && (n < budget)) begin
      tick();
      n++;
    end
    check(name, bus_if.o_Busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dv"},    bus_if.o_Tx_DV,      1'b0);
    check({tag, "_byte"},  bus_if.o_Tx_Byte,    8'h00);
    check({tag, "_busy"},  bus_if.o_Busy,       1'b0);
    check({tag, "_ovf"},   bus_if.o_Overflow,   1'b0);
    check({tag, "_ready"}, bus_if.o_Data_Ready, 1'b1);
  endtask

  logic [7:0] lit1 [6]  = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
  logic [7:0] lit2 [12] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                            8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
  logic [7:0] lit3 [6]  = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};

  initial begin
    int base;
    int n;
    bus_if.i_Data_Valid = 1'b0;
    bus_if.i_Data       = '0;
    rst_n               = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single word: latency, pulse width, done-to-DV gap, busy fall.
    base = obs_log.size();
    push(32'h12345678);
    check("lat_t0_dv", bus_if.o_Tx_DV, 1'b0);
    tick();
    check("lat_t1_dv", bus_if.o_Tx_DV, 1'b0);
    tick();
    check("lat_t2_dv", bus_if.o_Tx_DV, 1'b1);
    check("lat_t2_byte", bus_if.o_Tx_Byte, 8'hA5);
    for (int b = 0; b < FL; b++) begin
      n = 0;
      while (!bus_if.i_Tx_Done && (n < 100)) begin
        tick();
        n++;
      end
      check("done_seen", bus_if.i_Tx_Done, 1'b1);
      if (b < FL - 1) begin
        check("busy_mid_frame", bus_if.o_Busy, 1'b1);
        tick();
        check("done_to_dv_gap", bus_if.o_Tx_DV, 1'b1);
      end else begin
        check("busy_fall", bus_if.o_Busy, 1'b0);
      end
    end
    repeat (5) tick();
    check("frame1_count", obs_log.size() - base, 6);
    for (int i = 0; i < 6; i++) check("frame1_lit", obs_log[base + i], lit1[i]);

    // Back-to-back frames.
    base = obs_log.size();
    push(32'h00000000);
    push(32'hFFFFFFFF);
    wait_log(base + 12, 500, "b2b_timeout");
    wait_idle(100, "b2b_idle");
    for (int i = 0; i < 12; i++) check("b2b_lit", obs_log[base + i], lit2[i]);

    // Overflow: valid held for 8 cycles regardless of ready.
    base = obs_log.size();
    for (int i = 0; i < 8; i++) begin
      bus_if.i_Data_Valid = 1'b1;
      bus_if.i_Data       = 32'hC0DE0000 + 32'(i * 32'h0101);
      check("ovf_ready", bus_if.o_Data_Ready, (i < 5));
      check("ovf_flag_seq", bus_if.o_Overflow, (i >= 6));
      tick();
    end
    bus_if.i_Data_Valid = 1'b0;
    check("ovf_sticky", bus_if.o_Overflow, 1'b1);
    wait_log(base + 5 * FL, 2000, "ovf_frames_timeout");
    wait_idle(100, "ovf_idle");
    repeat (20) tick();
    check("ovf_frame_bytes", obs_log.size() - base, 5 * FL);
    check("ovf_still_set", bus_if.o_Overflow, 1'b1);

    // Reset during byte 3 of a frame with more words queued.
    base = obs_log.size();
    push(32'hA1B2C3D4);
    push(32'h11111111);
    push(32'h22222222);
    wait_log(base + 3, 300, "rst_byte3_timeout");
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    base = obs_log.size();
    inject_req++;
    repeat (40) tick();
    check("no_dv_after_reset", obs_log.size() - base, 0);
    check("fifo_empty_after_reset", bus_if.o_Busy, 1'b0);
    push(32'hDEADBEEF);
    wait_log(base + 6, 300, "post_reset_timeout");
    wait_idle(100, "post_reset_idle");
    for (int i = 0; i < 6; i++) check("post_reset_lit", obs_log[base + i], lit3[i]);

    // Stalled transmitter: byte held, no extra DV, FIFO fills.
    base  = obs_log.size();
    stall = 1'b1;
    push(32'h55AA55AA);
    wait_log(base + 1, 50, "stall_first_timeout");
    for (int i = 0; i < 5; i++) begin
      bus_if.i_Data_Valid = 1'b1;
      bus_if.i_Data       = 32'h0BAD0000 + 32'(i);
      check("stall_ready", bus_if.o_Data_Ready, (i < 4));
      tick();
    end
    bus_if.i_Data_Valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      check("stall_byte", bus_if.o_Tx_Byte, 8'hA5);
      check("stall_no_dv", bus_if.o_Tx_DV, 1'b0);
      tick();
    end
    check("stall_dv_count", obs_log.size() - base, 1);
    check("stall_full", bus_if.o_Data_Ready, 1'b0);
    stall = 1'b0;
    wait_log(base + 5 * FL, 3000, "stall_drain_timeout");
    wait_idle(100, "stall_idle");
    repeat (10) tick();
    check("stall_frame_bytes", obs_log.size() - base, 5 * FL);
    check("model_all_consumed", rd, exp_bytes.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_tx_framer.md
Name: tdc_tx_framer

Overview:
- Sits directly upstream of the UART transmitter and is the only block that drives its i_Tx_DV / i_Tx_Byte.
- Accepts DATA_W-bit TDC measurement words through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each word into a framed byte stream: header, data bytes MSB-first, XOR checksum.
- Paces bytes one at a time: pulses DV, then waits for the transmitter's done flag before issuing the next byte.

Parameters:
- DATA_W, 32: measurement word width; must be a multiple of NB and ≥ NB.
- NB, 8: UART byte width; must match the transmitter's NB.
- FIFO_DEPTH, 4: input FIFO entries; must be a power of 2, ≥ 2.
- HEADER, 8'hA5: frame sync byte.

Ports:
- i_Clock  in  1  system clock; all logic is on the rising edge.
- i_Reset_n  in  1  synchronous, active-low reset.
- i_Data_Valid  in  1  upstream word valid.
- i_Data  in  DATA_W  TDC measurement word.
- o_Data_Ready  out  1  FIFO not full; equals !full.
- i_Tx_Active  in  1  transmitter busy.
- i_Tx_Done  in  1  transmitter finished the current byte.
- o_Tx_DV  out  1  one-cycle byte-launch pulse.
- o_Tx_Byte  out  NB  byte to transmit; stable while waiting.
- o_Busy  out  1  high whenever state ≠ IDLE.
- o_Overflow  out  1  sticky flag: a word was offered while the FIFO was full.

Behaviour:
- Reset (i_Reset_n=0 at an edge):
  - FIFO empties; pointers and count go to 0.
  - State → IDLE; byte index → 0; checksum → 0.
  - o_Tx_DV=0, o_Tx_Byte=0, o_Busy=0, o_Overflow=0, o_Data_Ready=1.
  - Reset mid-frame abandons the frame. Any byte already launched may still complete on the line; the framer ignores i_Tx_Done until it has issued a new DV.
- FIFO:
  - Push when i_Data_Valid && !full.
  - Pop when state==IDLE && !empty && !i_Tx_Active.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - No fall-through: a pushed word is poppable from the next cycle.
  - i_Data_Valid && full: word dropped, o_Overflow set to 1; it clears only on reset.
- Frame: K = DATA_W/NB data bytes; total K+2 bytes per frame.
  - Byte 0: HEADER.
  - Bytes 1..K: word[DATA_W-1 -: NB] first, i.e. MSB-first.
  - Byte K+1: XOR of bytes 1..K; the header is excluded from the checksum.
- State machine (registered):
  - IDLE: on pop, latch the word into the shift register, clear the checksum, set index=0 → ISSUE.
  - ISSUE: o_Tx_DV=1 for exactly this one cycle. o_Tx_Byte = byte[index], held until the next ISSUE. When index is in 1..K, fold the byte into the checksum. → WAIT.
  - WAIT: hold until i_Tx_Done=1. Then:
    - if index<K+1: index+1 → ISSUE;
    - else: → IDLE.
  - Undefined state codes → IDLE.
- o_Tx_DV is never asserted outside ISSUE. ISSUE is reachable only from IDLE (with !i_Tx_Active) or from WAIT after i_Tx_Done, so a byte is never launched while the transmitter is busy.
- Latency:
  - Word pushed at edge t into an empty FIFO with the transmitter idle → pop at edge t+1 → o_Tx_DV high between edges t+2 and t+3.
  - Gap from i_Tx_Done high to the next DV is 1 cycle.
- Index counter width: $clog2(K+2); it never exceeds K+1.
- Checksum width: NB bits.

Test Plan:
- Single word: push 32'h12345678 with a UART model behind the framer → bytes A5,12,34,56,78,08 in order; exactly 6 DV pulses, each 1 cycle wide; o_Busy falls after the 6th done.
- Latency: push at edge t with the FIFO empty → o_Tx_DV high in the cycle after edge t+2; next DV exactly 1 cycle after each i_Tx_Done.
- Overflow: hold i_Data_Valid high for 8 consecutive cycles, ignoring ready → 5 words accepted, 3 dropped; o_Overflow=1 from the first drop; exactly 5 complete frames emitted; o_Data_Ready low while full.
- Back-to-back frames: push 32'h00000000 then 32'hFFFFFFFF → A5,00,00,00,00,00 then A5,FF,FF,FF,FF,00; no DV is asserted while i_Tx_Active=1.
- Reset mid-frame: assert i_Reset_n=0 during byte 3 of a frame → outputs return to reset values next edge; the FIFO is empty; a stray i_Tx_Done after release causes no DV; a new push yields a clean frame starting with A5.
- Stalled transmitter: hold i_Tx_Done=0 for 1000 cycles in WAIT → o_Tx_Byte stable, no extra DV, FIFO keeps accepting words until full.
